// File: rtl/i2c_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : i2c_txn_sequencer
// Brief   : Sequences one I2C transaction (flush, arm, byte count, drain)
//           with idle timeout and abort handling.
// Rev     : 1.0
// ============================================================================
module i2c_txn_sequencer #(
    parameter int FLUSH_CYC = 4,
    parameter int TMO_W     = 16
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             start,
    input  logic             abort,
    input  logic [6:0]       cfg_addr,
    input  logic             cfg_rw,
    input  logic [7:0]       cfg_len,
    input  logic [TMO_W-1:0] cfg_tmo,
    input  logic             i2c_ready,
    input  logic             rx_full,
    input  logic             byte_tog,
    output logic [7:0]       command,
    output logic [7:0]       addr_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [7:0]       bytes_left
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_ARM   = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [7:0] CMD_IDLE  = 8'hF0;
    localparam logic [7:0] CMD_FLUSH = 8'hC0;
    localparam logic [7:0] CMD_ARM   = 8'hF8;
    localparam logic [7:0] CMD_RUN   = 8'hFC;
    localparam logic [7:0] CMD_DRAIN = 8'hF8;
    localparam logic [7:0] CMD_DONE  = 8'hF8;
    localparam logic [7:0] CMD_ERR   = 8'hF0;

    localparam logic [1:0] ERR_LEN   = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;
    localparam logic [1:0] ERR_ABORT = 2'b11;

    localparam int FW = (FLUSH_CYC > 2) ? $clog2(FLUSH_CYC) : 1;

    state_t           state_q, state_d;
    logic [1:0]       rdy_sync_q, full_sync_q, tog_sync_q;
    logic             tog_dly_q;
    logic [6:0]       addr_q, addr_d;
    logic             rw_q, rw_d;
    logic [TMO_W-1:0] tmo_lim_q, tmo_lim_d;
    logic [TMO_W-1:0] tmo_q, tmo_d, tmo_nxt;
    logic [7:0]       bytes_q, bytes_d;
    logic [1:0]       code_q, code_d;
    logic [FW-1:0]    flush_q, flush_d;
    logic [7:0]       command_q, cmd_d;
    logic             done_q, err_q;
    logic             ready_s, full_s, byte_evt, busy_w, tmo_inc, tmo_hit;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rdy_sync_q  <= '0;
            full_sync_q <= '0;
            tog_sync_q  <= '0;
            tog_dly_q   <= 1'b0;
        end else begin
            rdy_sync_q  <= {rdy_sync_q[0], i2c_ready};
            full_sync_q <= {full_sync_q[0], rx_full};
            tog_sync_q  <= {tog_sync_q[0], byte_tog};
            tog_dly_q   <= tog_sync_q[1];
        end
    end

    assign ready_s  = rdy_sync_q[1];
    assign full_s   = full_sync_q[1];
    assign byte_evt = tog_sync_q[1] ^ tog_dly_q;
    assign busy_w   = (state_q != S_IDLE) && (state_q != S_ERR);

    // A read stalled on a full RX FIFO is the host's fault, not the bus's: hold the timer.
    assign tmo_inc  = (state_q == S_ARM) || (state_q == S_DRAIN) ||
                      ((state_q == S_RUN) && !(full_s && rw_q));
    assign tmo_nxt  = tmo_q + TMO_W'(1);
    // Fires on the edge the counter would reach the limit, so ARM lasts exactly cfg_tmo cycles.
    assign tmo_hit  = tmo_inc && (tmo_nxt == tmo_lim_q);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        tmo_lim_d = tmo_lim_q;
        bytes_d   = bytes_q;
        code_d    = code_q;
        flush_d   = '0;
        tmo_d     = tmo_q;
        cmd_d     = CMD_IDLE;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    addr_d    = cfg_addr;
                    rw_d      = cfg_rw;
                    tmo_lim_d = cfg_tmo;
                    bytes_d   = cfg_len;
                    code_d    = 2'b00;
                    if (cfg_len == 8'd0) begin
                        state_d = S_ERR;
                        code_d  = ERR_LEN;
                    end else begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                flush_d = flush_q + FW'(1);
                if (flush_q == FW'(FLUSH_CYC - 1)) state_d = S_ARM;
            end
            S_ARM: begin
                if (ready_s) begin
                    state_d = S_RUN;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                    code_d  = ERR_TMO;
                end
            end
            S_RUN: begin
                if (byte_evt) begin
                    bytes_d = bytes_q - 8'd1;
                    if (bytes_q == 8'd1) state_d = S_DRAIN;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                    code_d  = ERR_TMO;
                end
            end
            S_DRAIN: begin
                if (ready_s) begin
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                    code_d  = ERR_TMO;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort && busy_w) begin
            state_d = S_ERR;
            code_d  = ERR_ABORT;
            bytes_d = bytes_q;
        end

        if ((state_d != state_q) || byte_evt) begin
            tmo_d = '0;
        end else if (tmo_inc) begin
            tmo_d = tmo_nxt;
        end

        case (state_d)
            S_IDLE:  cmd_d = CMD_IDLE;
            S_FLUSH: cmd_d = CMD_FLUSH;
            S_ARM:   cmd_d = CMD_ARM;
            S_RUN:   cmd_d = CMD_RUN;
            S_DRAIN: cmd_d = CMD_DRAIN;
            S_DONE:  cmd_d = CMD_DONE;
            S_ERR:   cmd_d = CMD_ERR;
            default: cmd_d = CMD_IDLE;
        endcase
    end

    // Outputs are registered from next state so they line up with state_q yet read 00 in reset.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            tmo_lim_q <= '0;
            tmo_q     <= '0;
            bytes_q   <= '0;
            code_q    <= '0;
            flush_q   <= '0;
            command_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            tmo_lim_q <= tmo_lim_d;
            tmo_q     <= tmo_d;
            bytes_q   <= bytes_d;
            code_q    <= code_d;
            flush_q   <= flush_d;
            command_q <= cmd_d;
            done_q    <= (state_d == S_DONE);
            err_q     <= (state_d == S_ERR);
        end
    end

    assign command    = command_q;
    assign addr_out   = {addr_q, rw_q};
    assign busy       = busy_w;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = code_q;
    assign bytes_left = bytes_q;

endmodule
`default_nettype wire
